// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read, scoreboard hazard stall, output register.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data to sources.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    output logic [REG_AW-1:0] rf_rs1,
    output logic [REG_AW-1:0] rf_rs2,
    input  logic [DATA_W-1:0] rf_rs1_data,
    input  logic [DATA_W-1:0] rf_rs2_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic              sb_busy
);

    localparam int NREG = 1 << REG_AW;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nx;
    logic              in_fire;
    logic              out_fire;
    logic              wb_hit1;
    logic              wb_hit2;
    logic              wb_hit_rd;
    logic              byp1;
    logic              byp2;
    logic              hz1;
    logic              hz2;
    logic              waw;
    logic [DATA_W-1:0] op1_sel;
    logic [DATA_W-1:0] op2_sel;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    assign wb_hit1   = wb_valid & (wb_rd == in_rs1);
    assign wb_hit2   = wb_valid & (wb_rd == in_rs2);
    assign wb_hit_rd = wb_valid & (wb_rd == in_rd);

    assign byp1 = BYP & pending[in_rs1] & wb_hit1;
    assign byp2 = BYP & pending[in_rs2] & wb_hit2;

    assign hz1 = in_valid & pending[in_rs1] & ~byp1;
    assign hz2 = in_valid & pending[in_rs2] & ~byp2;
    assign waw = in_valid & in_wen & pending[in_rd] & ~wb_hit_rd;

    assign in_ready = ~hz1 & ~hz2 & ~waw
                    & (~out_valid | out_ready);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign op1_sel = byp1 ? wb_data : rf_rs1_data;
    assign op2_sel = byp2 ? wb_data : rf_rs2_data;

    assign sb_busy = |pending;

    // Scoreboard update: writeback clears first, so a same-cycle set wins.
    always_comb begin
        pending_nx = pending;
        if (wb_valid) begin
            pending_nx[wb_rd] = 1'b0;
        end
        if (in_fire && in_wen) begin
            pending_nx[in_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nx;
        end
    end

    // Output register: load on accept, drain on execute handshake, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_op1   <= op1_sel;
            out_op2   <= op2_sel;
            out_rd    <= in_rd;
            out_wen   <= in_wen;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hazard,
// back-pressure and reset sequences.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic [3:0]  rf_rs1;
    logic [3:0]  rf_rs2;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic        sb_busy;

    logic [31:0] rf [16];

    int total = 0;
    int bad   = 0;

    operand_fetch #(.DATA_W(32), .REG_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rs1_data(rf_rs1_data),
        .rf_rs2_data(rf_rs2_data),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .sb_busy    (sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rs1_data = rf[rf_rs1];
    assign rf_rs2_data = rf[rf_rs2];

    // Register file model: writeback commits at the rising edge.
    always @(posedge clk) begin
        if (wb_valid) rf[wb_rd] <= wb_data;
    end

    typedef struct {
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        wen;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic        e_busy;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rs1,
                         input logic [3:0] rs2,
                         input logic [3:0] rd,
                         input logic       wen);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_wen   = wen;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_wen   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd2, 4'd3, 4'd1,  1'b0, 32'h5,    32'h7,    1'b0};
        vecs[1] = '{4'd3, 4'd2, 4'd15, 1'b0, 32'h7,    32'h5,    1'b0};
        vecs[2] = '{4'd5, 4'd5, 4'd0,  1'b0, 32'h1005, 32'h1005, 1'b0};
        vecs[3] = '{4'd0, 4'd15,4'd8,  1'b0, 32'h1000, 32'h100F, 1'b0};
        vecs[4] = '{4'd7, 4'd7, 4'd7,  1'b1, 32'h1007, 32'h1007, 1'b1};
        vecs[5] = '{4'd1, 4'd14,4'd10, 1'b0, 32'h1001, 32'h100E, 1'b1};

        for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
        rf[2] = 32'h5;
        rf[3] = 32'h7;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_wen    = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b1;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_op1", out_op1, 0);
        check("rst_op2", out_op2, 0);
        check("rst_rd", out_rd, 0);
        check("rst_wen", out_wen, 0);
        check("rst_busy", sb_busy, 0);
        check("rst_in_ready", in_ready, 1);

        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: independent issues, one cycle latency each.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen);
            #1;
            check($sformatf("v%0d_ready", i), in_ready, 1);
            step();
            idle();
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_op1", i), out_op1, vecs[i].e_op1);
            check($sformatf("v%0d_op2", i), out_op2, vecs[i].e_op2);
            check($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            check($sformatf("v%0d_wen", i), out_wen, vecs[i].wen);
            check($sformatf("v%0d_busy", i), sb_busy, vecs[i].e_busy);
        end

        // Clear pending[7].
        wb_valid = 1'b1;
        wb_rd    = 4'd7;
        wb_data  = 32'h1007;
        step();
        wb_valid = 1'b0;
        check("clr7_busy", sb_busy, 0);
        check("idle_drain", out_valid, 0);

        // RAW stall on r4, then release by writeback.
        drive(4'd0, 4'd0, 4'd4, 1'b1);
        #1;
        check("raw_set_ready", in_ready, 1);
        step();
        drive(4'd4, 4'd0, 4'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("raw_stall%0d", c), in_ready, 0);
            check($sformatf("raw_busy%0d", c), sb_busy, 1);
            step();
        end
        wb_valid = 1'b1;
        wb_rd    = 4'd4;
        wb_data  = 32'h1234;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        check("byp_ready", in_ready, 1);
        step();
        wb_valid = 1'b0;
`else
        check("nobyp_stall", in_ready, 0);
        step();
        wb_valid = 1'b0;
        #1;
        check("nobyp_ready", in_ready, 1);
        step();
`endif
        idle();
        check("raw_valid", out_valid, 1);
        check("raw_op1", out_op1, 32'h1234);
        check("raw_busy_clr", sb_busy, 0);

        // WAW with same-cycle writeback: accepted, bit stays set.
        drive(4'd1, 4'd1, 4'd6, 1'b1);
        step();
        drive(4'd1, 4'd1, 4'd6, 1'b1);
        wb_valid = 1'b1;
        wb_rd    = 4'd6;
        wb_data  = 32'h66;
        #1;
        check("waw_wb_ready", in_ready, 1);
        step();
        wb_valid = 1'b0;
        check("waw_out_rd", out_rd, 6);
        check("waw_busy", sb_busy, 1);
        #1;
        check("waw_stall", in_ready, 0);
        idle();
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        check("waw_clear", sb_busy, 0);

        // Back-pressure: hold output, then issue with no bubble.
        out_ready = 1'b0;
        step();
        drive(4'd2, 4'd3, 4'd11, 1'b0);
        step();
        drive(4'd8, 4'd9, 4'd12, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("bp_ready%0d", c), in_ready, 0);
            check($sformatf("bp_valid%0d", c), out_valid, 1);
            check($sformatf("bp_op1_%0d", c), out_op1, 32'h5);
            check($sformatf("bp_op2_%0d", c), out_op2, 32'h7);
            check($sformatf("bp_rd%0d", c), out_rd, 11);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", in_ready, 1);
        step();
        idle();
        check("bp_new_valid", out_valid, 1);
        check("bp_new_op1", out_op1, 32'h1008);
        check("bp_new_op2", out_op2, 32'h1009);
        check("bp_new_rd", out_rd, 12);
        step();
        check("bp_drain", out_valid, 0);

        // Reset mid-flight clears scoreboard and output.
        drive(4'd0, 4'd0, 4'd9, 1'b1);
        step();
        idle();
        check("pre_rst_busy", sb_busy, 1);
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", sb_busy, 0);
        step();
        rst_n = 1'b1;
        drive(4'd9, 4'd0, 4'd0, 1'b0);
        #1;
        check("post_rst_ready", in_ready, 1);
        step();
        idle();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_op1", out_op1, 32'h1009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
